fwrisc_dbus_decode: RTL and testbench

- Sits directly downstream of the core's load/store unit, on its external data bus (dvalid/daddr/dwdata/dwstb/dwrite, drdata/dready).
- Decodes each request address and forwards the request to one of two targets: data RAM or peripheral (MMIO) space.
- Returns the target's response to the core as a single-cycle dready pulse.
- Unmapped addresses and non-responding targets complete with an error instead of hanging the core.

---
 rtl/fwrisc_dbus_pkg.sv | 27 ++
 rtl/fwrisc_dbus_region_match.sv | 23 ++
 rtl/fwrisc_dbus_decode.sv | 236 +++++++++++++++++++++++
 tb/tb_fwrisc_dbus_decode.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fwrisc_dbus_pkg.sv
// fwrisc_dbus_pkg
// Shared definitions for the fwrisc data-bus address decoder:
//   - state_t   : decoder FSM state encoding
//   - region_t  : which target a request address maps to
//   - DEFAULT_* : default region bases, sizes and target timeout
package fwrisc_dbus_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_RAM = 2'd1,
        WAIT_PER = 2'd2,
        RESP     = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        REGION_NONE = 2'd0,
        REGION_RAM  = 2'd1,
        REGION_PER  = 2'd2
    } region_t;

    localparam logic [31:0] DEFAULT_RAM_BASE      = 32'h8000_0000;
    localparam int          DEFAULT_RAM_SIZE_LOG2 = 16;
    localparam logic [31:0] DEFAULT_PER_BASE      = 32'hC000_0000;
    localparam int          DEFAULT_PER_SIZE_LOG2 = 12;
    localparam int          DEFAULT_TIMEOUT       = 16;

endpackage

// File: rtl/fwrisc_dbus_region_match.sv
// fwrisc_dbus_region_match
// Combinational check of whether a byte address falls inside an aligned
// power-of-two region [BASE, BASE + 2**SIZE_LOG2).
// Ports:
//   addr  in  32  byte address to test
//   hit   out 1   address lies within the region
module fwrisc_dbus_region_match #(
    parameter logic [31:0] BASE      = 32'h0000_0000,
    parameter int          SIZE_LOG2 = 12
) (
    input  logic [31:0] addr,
    output logic        hit
);

    // Only the bits above the region size take part in the compare.  This is
    // the same as comparing addr >> SIZE_LOG2 against BASE >> SIZE_LOG2, but
    // keeps every address bit visibly in use.
    localparam logic [31:0] MASK = (SIZE_LOG2 >= 32) ? 32'd0
                                 : ~((32'd1 << SIZE_LOG2) - 32'd1);

    assign hit = (((addr ^ BASE) & MASK) == 32'd0);

endmodule

// File: rtl/fwrisc_dbus_decode.sv
// fwrisc_dbus_decode
// Decodes core data-bus requests onto a RAM target or a peripheral (MMIO)
// target and returns the selected target's response to the core as a
// one-cycle dready pulse.  Unmapped addresses and targets that never respond
// complete with derr=1.  All outputs are registered.
// Ports:
//   clock, reset                    clock and asynchronous active-low reset
//   dvalid/daddr/dwdata/dwstb/dwrite core request (held until dready)
//   drdata/dready/derr              response to the core
//   ram_*                           RAM target request/response
//   per_*                           peripheral target request/response
module fwrisc_dbus_decode
    import fwrisc_dbus_pkg::*;
#(
    parameter logic [31:0] RAM_BASE      = DEFAULT_RAM_BASE,
    parameter int          RAM_SIZE_LOG2 = DEFAULT_RAM_SIZE_LOG2,
    parameter logic [31:0] PER_BASE      = DEFAULT_PER_BASE,
    parameter int          PER_SIZE_LOG2 = DEFAULT_PER_SIZE_LOG2,
    parameter int          TIMEOUT       = DEFAULT_TIMEOUT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        dvalid,
    input  logic [31:0] daddr,
    input  logic [31:0] dwdata,
    input  logic [3:0]  dwstb,
    input  logic        dwrite,
    output logic [31:0] drdata,
    output logic        dready,
    output logic        derr,
    output logic        ram_valid,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    output logic [3:0]  ram_wstb,
    output logic        ram_write,
    input  logic [31:0] ram_rdata,
    input  logic        ram_ready,
    output logic        per_valid,
    output logic [31:0] per_addr,
    output logic [31:0] per_wdata,
    output logic [3:0]  per_wstb,
    output logic        per_write,
    input  logic [31:0] per_rdata,
    input  logic        per_ready
);

    localparam logic [31:0] TMO_LAST = (TIMEOUT == 0) ? 32'd0 : 32'(TIMEOUT - 1);

    state_t      state, state_n;
    logic [31:0] tmo_cnt, tmo_cnt_n;
    region_t     region;
    logic        ram_hit, per_hit;

    logic [31:0] drdata_n;
    logic        dready_n, derr_n;
    logic        ram_valid_n, ram_write_n, per_valid_n, per_write_n;
    logic [31:0] ram_addr_n, ram_wdata_n, per_addr_n, per_wdata_n;
    logic [3:0]  ram_wstb_n, per_wstb_n;

    fwrisc_dbus_region_match #(
        .BASE      (RAM_BASE),
        .SIZE_LOG2 (RAM_SIZE_LOG2)
    ) u_ram_match (
        .addr (daddr),
        .hit  (ram_hit)
    );

    fwrisc_dbus_region_match #(
        .BASE      (PER_BASE),
        .SIZE_LOG2 (PER_SIZE_LOG2)
    ) u_per_match (
        .addr (daddr),
        .hit  (per_hit)
    );

    // RAM takes priority when the two regions overlap.
    always_comb begin
        region = REGION_NONE;
        if (ram_hit) begin
            region = REGION_RAM;
        end else if (per_hit) begin
            region = REGION_PER;
        end
    end

    // Next-state and next-output logic.  Every registered output defaults to
    // holding its value, so drdata and the target address/data stay put
    // until something deliberately changes them.  A target's ready is only
    // looked at while waiting on that target, which is what makes stray or
    // late ready pulses harmless.
    always_comb begin
        state_n     = state;
        tmo_cnt_n   = tmo_cnt;
        drdata_n    = drdata;
        dready_n    = dready;
        derr_n      = derr;
        ram_valid_n = ram_valid;
        ram_addr_n  = ram_addr;
        ram_wdata_n = ram_wdata;
        ram_wstb_n  = ram_wstb;
        ram_write_n = ram_write;
        per_valid_n = per_valid;
        per_addr_n  = per_addr;
        per_wdata_n = per_wdata;
        per_wstb_n  = per_wstb;
        per_write_n = per_write;

        case (state)
            IDLE: begin
                if (dvalid && !dready) begin
                    case (region)
                        REGION_RAM: begin
                            ram_valid_n = 1'b1;
                            ram_addr_n  = daddr - RAM_BASE;
                            ram_wdata_n = dwdata;
                            ram_wstb_n  = dwstb;
                            ram_write_n = dwrite;
                            state_n     = WAIT_RAM;
                        end
                        REGION_PER: begin
                            per_valid_n = 1'b1;
                            per_addr_n  = daddr - PER_BASE;
                            per_wdata_n = dwdata;
                            per_wstb_n  = dwstb;
                            per_write_n = dwrite;
                            state_n     = WAIT_PER;
                        end
                        default: begin
                            drdata_n = 32'd0;
                            derr_n   = 1'b1;
                            dready_n = 1'b1;
                            state_n  = RESP;
                        end
                    endcase
                end
            end

            WAIT_RAM: begin
                if (ram_ready) begin
                    ram_valid_n = 1'b0;
                    ram_write_n = 1'b0;
                    ram_wstb_n  = 4'd0;
                    drdata_n    = ram_write ? 32'd0 : ram_rdata;
                    derr_n      = 1'b0;
                    dready_n    = 1'b1;
                    tmo_cnt_n   = 32'd0;
                    state_n     = RESP;
                end else if (TIMEOUT != 0 && tmo_cnt == TMO_LAST) begin
                    ram_valid_n = 1'b0;
                    ram_write_n = 1'b0;
                    ram_wstb_n  = 4'd0;
                    drdata_n    = 32'd0;
                    derr_n      = 1'b1;
                    dready_n    = 1'b1;
                    tmo_cnt_n   = 32'd0;
                    state_n     = RESP;
                end else begin
                    tmo_cnt_n = tmo_cnt + 32'd1;
                end
            end

            WAIT_PER: begin
                if (per_ready) begin
                    per_valid_n = 1'b0;
                    per_write_n = 1'b0;
                    per_wstb_n  = 4'd0;
                    drdata_n    = per_write ? 32'd0 : per_rdata;
                    derr_n      = 1'b0;
                    dready_n    = 1'b1;
                    tmo_cnt_n   = 32'd0;
                    state_n     = RESP;
                end else if (TIMEOUT != 0 && tmo_cnt == TMO_LAST) begin
                    per_valid_n = 1'b0;
                    per_write_n = 1'b0;
                    per_wstb_n  = 4'd0;
                    drdata_n    = 32'd0;
                    derr_n      = 1'b1;
                    dready_n    = 1'b1;
                    tmo_cnt_n   = 32'd0;
                    state_n     = RESP;
                end else begin
                    tmo_cnt_n = tmo_cnt + 32'd1;
                end
            end

            RESP: begin
                dready_n = 1'b0;
                derr_n   = 1'b0;
                state_n  = IDLE;
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State, timeout counter and every output are registered here; reset
    // clears all of them without waiting for a clock edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            tmo_cnt   <= 32'd0;
            drdata    <= 32'd0;
            dready    <= 1'b0;
            derr      <= 1'b0;
            ram_valid <= 1'b0;
            ram_addr  <= 32'd0;
            ram_wdata <= 32'd0;
            ram_wstb  <= 4'd0;
            ram_write <= 1'b0;
            per_valid <= 1'b0;
            per_addr  <= 32'd0;
            per_wdata <= 32'd0;
            per_wstb  <= 4'd0;
            per_write <= 1'b0;
        end else begin
            state     <= state_n;
            tmo_cnt   <= tmo_cnt_n;
            drdata    <= drdata_n;
            dready    <= dready_n;
            derr      <= derr_n;
            ram_valid <= ram_valid_n;
            ram_addr  <= ram_addr_n;
            ram_wdata <= ram_wdata_n;
            ram_wstb  <= ram_wstb_n;
            ram_write <= ram_write_n;
            per_valid <= per_valid_n;
            per_addr  <= per_addr_n;
            per_wdata <= per_wdata_n;
            per_wstb  <= per_wstb_n;
            per_write <= per_write_n;
        end
    end

endmodule

// File: tb/tb_fwrisc_dbus_decode.sv
// tb_fwrisc_dbus_decode
// Table-driven bench for fwrisc_dbus_decode: each record is one core
// request plus the target behaviour to emulate and the expected response,
// followed by hand-written sequences for late ready pulses and async reset.
module tb_fwrisc_dbus_decode;

    localparam int TGT_NONE = 0;
    localparam int TGT_RAM  = 1;
    localparam int TGT_PER  = 2;
    localparam int NEVER    = -1;
    localparam int BOUND    = 40;

    logic        clock;
    logic        reset;
    logic        dvalid;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic [3:0]  dwstb;
    logic        dwrite;
    logic [31:0] drdata;
    logic        dready;
    logic        derr;
    logic        ram_valid;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [3:0]  ram_wstb;
    logic        ram_write;
    logic [31:0] ram_rdata;
    logic        ram_ready;
    logic        per_valid;
    logic [31:0] per_addr;
    logic [31:0] per_wdata;
    logic [3:0]  per_wstb;
    logic        per_write;
    logic [31:0] per_rdata;
    logic        per_ready;

    int errors;
    int checks;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstb;
        logic        write;
        int          waits;
        logic [31:0] rdata;
        logic        noise;
        int          tgt;
        logic [31:0] off;
        int          tgt_cycles;
        int          lat;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[10];

    fwrisc_dbus_decode dut (
        .clock     (clock),
        .reset     (reset),
        .dvalid    (dvalid),
        .daddr     (daddr),
        .dwdata    (dwdata),
        .dwstb     (dwstb),
        .dwrite    (dwrite),
        .drdata    (drdata),
        .dready    (dready),
        .derr      (derr),
        .ram_valid (ram_valid),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_wstb  (ram_wstb),
        .ram_write (ram_write),
        .ram_rdata (ram_rdata),
        .ram_ready (ram_ready),
        .per_valid (per_valid),
        .per_addr  (per_addr),
        .per_wdata (per_wdata),
        .per_wstb  (per_wstb),
        .per_write (per_write),
        .per_rdata (per_rdata),
        .per_ready (per_ready)
    );

    // Free-running 10-time-unit clock.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic vec_t mk(
        input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstb,
        input logic write, input int waits, input logic [31:0] rdata,
        input logic noise, input int tgt, input logic [31:0] off,
        input int tgt_cycles, input int lat, input logic [31:0] exp_rdata,
        input logic exp_err);
        vec_t v;
        v.addr = addr;   v.wdata = wdata; v.wstb = wstb;   v.write = write;
        v.waits = waits; v.rdata = rdata; v.noise = noise; v.tgt = tgt;
        v.off = off;     v.tgt_cycles = tgt_cycles;        v.lat = lat;
        v.exp_rdata = exp_rdata;          v.exp_err = exp_err;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Drives one request, emulates the addressed target with the given wait
    // count, and checks the response, latency and target-side activity.
    task automatic applyStimulus(input vec_t v, input string tag);
        int cyc, rc, pc, bad, lat;
        logic [31:0] got_rd;
        logic got_err, done;
        dvalid = 1'b1;
        daddr  = v.addr;
        dwdata = v.wdata;
        dwstb  = v.wstb;
        dwrite = v.write;
        cyc = 0; rc = 0; pc = 0; bad = 0; lat = 0;
        done = 1'b0; got_rd = '0; got_err = 1'b0;
        while (!done && cyc < BOUND) begin
            @(negedge clock);
            cyc++;
            ram_ready = 1'b0;
            per_ready = 1'b0;
            ram_rdata = 32'h0BAD_0BAD;
            per_rdata = 32'h0BAD_1BAD;
            if (ram_valid) begin
                rc++;
                if (ram_addr !== v.off || ram_wstb !== v.wstb ||
                    ram_write !== v.write || ram_wdata !== v.wdata) bad++;
                if (v.tgt == TGT_RAM && v.waits != NEVER && rc == v.waits + 1) begin
                    ram_ready = 1'b1;
                    ram_rdata = v.rdata;
                end
            end
            if (per_valid) begin
                pc++;
                if (per_addr !== v.off || per_wstb !== v.wstb ||
                    per_write !== v.write || per_wdata !== v.wdata) bad++;
                if (v.tgt == TGT_PER && v.waits != NEVER && pc == v.waits + 1) begin
                    per_ready = 1'b1;
                    per_rdata = v.rdata;
                end
            end
            if (v.noise) begin
                if (v.tgt == TGT_PER) ram_ready = 1'b1;
                else if (v.tgt == TGT_RAM) per_ready = 1'b1;
            end
            if (dready) begin
                done    = 1'b1;
                lat     = cyc;
                got_rd  = drdata;
                got_err = derr;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s_bound: no dready within %0d cycles", tag, BOUND);
        end else begin
            checkOutput({tag, "_latency"}, 32'(lat), 32'(v.lat));
            checkOutput({tag, "_drdata"}, got_rd, v.exp_rdata);
            checkOutput({tag, "_derr"}, 32'(got_err), 32'(v.exp_err));
        end
        checkOutput({tag, "_ram_cycles"}, 32'(rc), (v.tgt == TGT_RAM) ? 32'(v.tgt_cycles) : 32'd0);
        checkOutput({tag, "_per_cycles"}, 32'(pc), (v.tgt == TGT_PER) ? 32'(v.tgt_cycles) : 32'd0);
        checkOutput({tag, "_tgt_fields"}, 32'(bad), 32'd0);
        @(posedge clock);
        #1;
        dvalid    = 1'b0;
        ram_ready = 1'b0;
        per_ready = 1'b0;
        @(negedge clock);
        checkOutput({tag, "_dready_drop"}, 32'(dready), 32'd0);
        checkOutput({tag, "_drdata_hold"}, drdata, v.exp_rdata);
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        reset     = 1'b1;
        dvalid    = 1'b0;
        daddr     = '0;
        dwdata    = '0;
        dwstb     = '0;
        dwrite    = 1'b0;
        ram_rdata = '0;
        ram_ready = 1'b0;
        per_rdata = '0;
        per_ready = 1'b0;

        //            addr          wdata         wstb     wr  waits  rdata         nz  tgt       off           cyc lat exp_rdata     err
        vecs[0] = mk(32'h8000_0010, 32'h0,        4'b0000, 0,  0,     32'h1234_5678, 0, TGT_RAM,  32'h0000_0010, 1,  2, 32'h1234_5678, 0);
        vecs[1] = mk(32'hC000_0004, 32'hABCD_ABCD, 4'b1100, 1, 3,     32'hDEAD_BEEF, 1, TGT_PER,  32'h0000_0004, 4,  5, 32'h0,         0);
        vecs[2] = mk(32'h0000_1000, 32'h5A5A_5A5A, 4'b1111, 1, 0,     32'h0,         0, TGT_NONE, 32'h0,         0,  1, 32'h0,         1);
        vecs[3] = mk(32'h8000_FFFC, 32'h0,        4'b0000, 0,  2,     32'hCAFE_F00D, 1, TGT_RAM,  32'h0000_FFFC, 3,  4, 32'hCAFE_F00D, 0);
        vecs[4] = mk(32'h8001_0000, 32'h0,        4'b0000, 0,  0,     32'h0,         0, TGT_NONE, 32'h0,         0,  1, 32'h0,         1);
        vecs[5] = mk(32'hC000_0FFC, 32'h0,        4'b0000, 0,  0,     32'h5555_AAAA, 0, TGT_PER,  32'h0000_0FFC, 1,  2, 32'h5555_AAAA, 0);
        vecs[6] = mk(32'hC000_1000, 32'h0,        4'b0000, 0,  0,     32'h0,         0, TGT_NONE, 32'h0,         0,  1, 32'h0,         1);
        vecs[7] = mk(32'h8000_0100, 32'h1122_3344, 4'b0011, 1, 1,     32'h7777_7777, 0, TGT_RAM,  32'h0000_0100, 2,  3, 32'h0,         0);
        vecs[8] = mk(32'h8000_0020, 32'h0,        4'b0000, 0,  NEVER, 32'h0,         0, TGT_RAM,  32'h0000_0020, 16, 17, 32'h0,        1);
        vecs[9] = mk(32'hC000_0008, 32'h0,        4'b0000, 0,  NEVER, 32'h0,         0, TGT_PER,  32'h0000_0008, 16, 17, 32'h0,        1);

        #1 reset = 1'b0;
        #2;
        checkOutput("reset_outputs",
                    32'({drdata, dready, derr, ram_valid, ram_addr, ram_wdata, ram_wstb, ram_write,
                         per_valid, per_addr, per_wdata, per_wstb, per_write} != '0), 32'd0);
        checkOutput("reset_dready", 32'(dready), 32'd0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);

        // Requests run back to back: each one is raised the cycle after the
        // previous dvalid was dropped.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i], $sformatf("vec%0d", i));
        end

        // Late / stray ready pulses on both targets while idle.
        ram_ready = 1'b1; ram_rdata = 32'hFFFF_FFFF;
        per_ready = 1'b1; per_rdata = 32'hEEEE_EEEE;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            checkOutput($sformatf("late_ready_dready%0d", i), 32'(dready), 32'd0);
            checkOutput($sformatf("late_ready_valids%0d", i), 32'({ram_valid, per_valid}), 32'd0);
        end
        checkOutput("late_ready_drdata", drdata, 32'h0);
        ram_ready = 1'b0;
        per_ready = 1'b0;
        @(negedge clock);

        // Async reset while waiting on a peripheral that never answers.
        dvalid = 1'b1; daddr = 32'hC000_0008; dwdata = 32'h0; dwstb = 4'b0000; dwrite = 1'b0;
        repeat (3) @(negedge clock);
        checkOutput("pre_reset_per_valid", 32'(per_valid), 32'd1);
        #2;
        reset  = 1'b0;
        dvalid = 1'b0;
        #1;
        checkOutput("mid_reset_outputs",
                    32'({drdata, dready, derr, ram_valid, ram_addr, ram_wdata, ram_wstb, ram_write,
                         per_valid, per_addr, per_wdata, per_wstb, per_write} != '0), 32'd0);
        checkOutput("mid_reset_per_addr", per_addr, 32'h0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        applyStimulus(vecs[0], "post_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
